game_over_sequencer: RTL and testbench



---
 rtl/game_over_sequencer_if.sv | 41 ++++
 rtl/game_over_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_game_over_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_over_sequencer_if.sv
// Overlay sequencer bundle: game-state strobes and key in, overlay controls out.
// The game-logic side uses the master modport; the sequencer uses the slave.
// dbg_state mirrors the sequencer's FSM state so checkers can bind to it.
interface game_over_sequencer_if;
    // Inputs to the sequencer
    logic        startOfFrame;     // one-cycle pulse per video frame
    logic        gameOverEvent;    // one-cycle pulse from game logic
    logic        restartKey;       // synchronized level, active-high

    // Outputs from the sequencer
    logic        overlayVisible;   // overlay 'visible' input
    logic [10:0] overlayTopLeftX;  // constant overlay X
    logic [10:0] overlayTopLeftY;  // animated overlay Y
    logic        restartRequest;   // one-cycle restart pulse to game controller
    logic        busy;             // high outside IDLE
    logic [2:0]  dbg_state;        // current FSM state encoding

    modport master (
        output startOfFrame,
        output gameOverEvent,
        output restartKey,
        input  overlayVisible,
        input  overlayTopLeftX,
        input  overlayTopLeftY,
        input  restartRequest,
        input  busy,
        input  dbg_state
    );

    modport slave (
        input  startOfFrame,
        input  gameOverEvent,
        input  restartKey,
        output overlayVisible,
        output overlayTopLeftX,
        output overlayTopLeftY,
        output restartRequest,
        output busy,
        output dbg_state
    );
endinterface

// File: rtl/game_over_sequencer.sv
// game_over_sequencer: drives the full-screen GAME OVER overlay.
// Sequence on a game-over pulse: drop-in animation, blink, hold for the
// restart key, then a one-cycle restart request. Clocked by the pixel clock.
// Optional macro GAMEOVER_TIMEOUT_EN: HOLD auto-restarts after TIMEOUT_FRAMES
// frame ticks if the key is never pressed.
//
// Strobe semantics: startOfFrame and gameOverEvent are single-cycle pulses
// sampled on the rising clock edge; there is no back-pressure. restartRequest
// is a single-cycle pulse the consumer must accept in the cycle it is high.
module game_over_sequencer #(
    parameter int X_POS          = 170,
    parameter int START_Y        = 0,
    parameter int FINAL_Y        = 10,
    parameter int DROP_STEP      = 4,
    parameter int BLINK_FRAMES   = 8,
    parameter int BLINK_TOGGLES  = 6,
    parameter int TIMEOUT_FRAMES = 600
) (
    input  logic                  clk,
    input  logic                  resetN,
    game_over_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DROP    = 3'd1,
        ST_BLINK   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RESTART = 3'd4
    } state_t;

    localparam logic [10:0] START_Y_L     = 11'(START_Y);
    localparam logic [10:0] FINAL_Y_L     = 11'(FINAL_Y);
    localparam logic [11:0] FINAL_Y_12    = 12'(FINAL_Y);
    localparam logic [11:0] DROP_STEP_12  = 12'(DROP_STEP);
    localparam logic [15:0] BLINK_LAST    = 16'(BLINK_FRAMES - 1);
    localparam logic [15:0] TOGGLE_LAST   = 16'(BLINK_TOGGLES - 1);

    state_t      state_q,  state_d;
    logic        vis_q,    vis_d;
    logic [10:0] y_q,      y_d;
    logic        req_q,    req_d;
    logic        busy_q,   busy_d;
    logic [15:0] frame_q,  frame_d;    // frames within the current blink half-period
    logic [15:0] toggle_q, toggle_d;   // visibility toggles done in BLINK
    logic        armed_q,  armed_d;    // key seen released while in HOLD

`ifdef GAMEOVER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_FRAMES - 1);
    logic [15:0] hold_cnt_q, hold_cnt_d;   // frame ticks spent in HOLD
`else
    // Timeout is compiled out; keep the parameter referenced so it is not
    // reported as dangling.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_FRAMES;
`endif

    logic [11:0] y_sum;
    logic [10:0] y_clamped;

    // Next drop position: 12-bit sum so it cannot wrap, then clamp to FINAL_Y.
    always_comb begin
        y_sum     = {1'b0, y_q} + DROP_STEP_12;
        y_clamped = y_sum[10:0];
        if (y_sum >= FINAL_Y_12) begin
            y_clamped = FINAL_Y_L;
        end
    end

    // State and output registers; async active-low reset to the idle values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            vis_q    <= 1'b0;
            y_q      <= START_Y_L;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            frame_q  <= '0;
            toggle_q <= '0;
            armed_q  <= 1'b0;
`ifdef GAMEOVER_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vis_q    <= vis_d;
            y_q      <= y_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            frame_q  <= frame_d;
            toggle_q <= toggle_d;
            armed_q  <= armed_d;
`ifdef GAMEOVER_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_d  = state_q;
        vis_d    = vis_q;
        y_d      = y_q;
        req_d    = 1'b0;
        busy_d   = busy_q;
        frame_d  = frame_q;
        toggle_d = toggle_q;
        armed_d  = armed_q;
`ifdef GAMEOVER_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A frame tick coincident with the event is deliberately not
                // counted; the first step happens on the next tick.
                if (bus.gameOverEvent) begin
                    state_d  = ST_DROP;
                    y_d      = START_Y_L;
                    vis_d    = 1'b1;
                    busy_d   = 1'b1;
                    frame_d  = '0;
                    toggle_d = '0;
                    armed_d  = 1'b0;
                end
            end

            ST_DROP: begin
                if (bus.startOfFrame) begin
                    y_d = y_clamped;
                    if (y_clamped == FINAL_Y_L) begin
                        state_d  = ST_BLINK;
                        frame_d  = '0;
                        toggle_d = '0;
                    end
                end
            end

            ST_BLINK: begin
                if (bus.startOfFrame) begin
                    if (frame_q == BLINK_LAST) begin
                        frame_d  = '0;
                        vis_d    = ~vis_q;
                        toggle_d = toggle_q + 16'd1;
                        if (toggle_q == TOGGLE_LAST) begin
                            // Last toggle: settle visible and wait for the key.
                            state_d = ST_HOLD;
                            vis_d   = 1'b1;
                            armed_d = 1'b0;
`ifdef GAMEOVER_TIMEOUT_EN
                            hold_cnt_d = '0;
`endif
                        end
                    end else begin
                        frame_d = frame_q + 16'd1;
                    end
                end
            end

            ST_HOLD: begin
                // Arming needs a released key first, so a key still held down
                // from gameplay cannot skip the screen.
                if (!bus.restartKey) begin
                    armed_d = 1'b1;
                end
                if (armed_q && bus.restartKey) begin
                    state_d = ST_RESTART;
                    req_d   = 1'b1;
                end
`ifdef GAMEOVER_TIMEOUT_EN
                else if (bus.startOfFrame) begin
                    if (hold_cnt_q == TIMEOUT_LAST) begin
                        state_d = ST_RESTART;
                        req_d   = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                    end
                end
`endif
            end

            ST_RESTART: begin
                // restartRequest is high for this single cycle only.
                state_d = ST_IDLE;
                vis_d   = 1'b0;
                y_d     = START_Y_L;
                armed_d = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                vis_d   = 1'b0;
                y_d     = START_Y_L;
                busy_d  = 1'b0;
                armed_d = 1'b0;
            end
        endcase
    end

    assign bus.overlayVisible  = vis_q;
    assign bus.overlayTopLeftX = 11'(X_POS);
    assign bus.overlayTopLeftY = y_q;
    assign bus.restartRequest  = req_q;
    assign bus.busy            = busy_q;
    assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_game_over_sequencer.sv
// Directed bench for game_over_sequencer: drop, blink, stuck key, ignored
// events, reset mid-sequence and the HOLD timeout (both builds).
module tb_game_over_sequencer;

    localparam int W = 12;   // scoreboard entry: {overlayVisible, overlayTopLeftY}

    logic clk = 1'b0;
    logic resetN;

    game_over_sequencer_if bus ();

    game_over_sequencer #(
        .X_POS          (170),
        .START_Y        (0),
        .FINAL_Y        (10),
        .DROP_STEP      (4),
        .BLINK_FRAMES   (8),
        .BLINK_TOGGLES  (6),
        .TIMEOUT_FRAMES (5)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int req_count = 0;
    logic [W-1:0] exp_q[$];

    // Count restartRequest cycles on the falling edge, away from updates.
    always @(negedge clk) begin
        if (bus.restartRequest === 1'b1) req_count++;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic frame_tick();
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
    endtask

    // Pop the next expected {vis, y} and compare with the DUT.
    task automatic sb_check(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {bus.overlayVisible, bus.overlayTopLeftY}, e);
        end
    endtask

    // Game-over event, full drop and blink; leaves the DUT just inside HOLD.
    task automatic run_to_hold(input bit with_sof, input bit poke_event);
        int  y;
        logic v;
        bus.gameOverEvent = 1'b1;
        bus.startOfFrame  = with_sof;
        step();
        bus.gameOverEvent = 1'b0;
        bus.startOfFrame  = 1'b0;
        check("enter_busy", bus.busy, 1);
        check("enter_vis",  bus.overlayVisible, 1);
        check("enter_y",    bus.overlayTopLeftY, 0);
        check("enter_state", bus.dbg_state, 1);

        y = 0;
        for (int i = 0; i < 3; i++) begin
            y = (y + 4 >= 10) ? 10 : y + 4;
            exp_q.push_back({1'b1, 11'(y)});
            frame_tick();
            sb_check("drop");
            idle_gap();
        end
        check("blink_state", bus.dbg_state, 2);

        v = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            if (k % 8 == 0) v = ~v;
            if (k == 48) v = 1'b1;
            exp_q.push_back({v, 11'd10});
            frame_tick();
            sb_check("blink");
            if (poke_event && k == 20) begin
                bus.gameOverEvent = 1'b1;
                step();
                bus.gameOverEvent = 1'b0;
                check("ignore_ev_y",     bus.overlayTopLeftY, 10);
                check("ignore_ev_vis",   bus.overlayVisible, v);
                check("ignore_ev_state", bus.dbg_state, 2);
            end
            idle_gap();
        end
        check("hold_state", bus.dbg_state, 3);
        check("hold_vis",   bus.overlayVisible, 1);
    endtask

    initial begin
        int base;
        bus.startOfFrame  = 1'b0;
        bus.gameOverEvent = 1'b0;
        bus.restartKey    = 1'b1;     // held from gameplay through the first run
        resetN            = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Reset state
        check("rst_vis",   bus.overlayVisible, 0);
        check("rst_y",     bus.overlayTopLeftY, 0);
        check("rst_x",     bus.overlayTopLeftX, 170);
        check("rst_req",   bus.restartRequest, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_state", bus.dbg_state, 0);
        resetN = 1'b1;
        step();

        // Drop (event coincides with a frame tick), blink with an ignored
        // event, key held down the whole time.
        run_to_hold(1'b1, 1'b1);
        check("x_const", bus.overlayTopLeftX, 170);

        // Stuck key: no restart while the key was never released.
        for (int i = 0; i < 20; i++) step();
        check("stuck_req_count", req_count, 0);
        check("stuck_state", bus.dbg_state, 3);

        // Release, then press: one-cycle request, idle one cycle later.
        bus.restartKey = 1'b0;
        step();
        bus.restartKey = 1'b1;
        step();
        check("press_req",  bus.restartRequest, 1);
        check("press_busy", bus.busy, 1);
        bus.restartKey = 1'b0;
        step();
        check("after_req",   bus.restartRequest, 0);
        check("after_busy",  bus.busy, 0);
        check("after_vis",   bus.overlayVisible, 0);
        check("after_y",     bus.overlayTopLeftY, 0);
        check("after_state", bus.dbg_state, 0);
        step();
        check("req_pulse_len", req_count, 1);

        // Second run: event during the RESTART cycle is ignored.
        run_to_hold(1'b0, 1'b0);
        step();                       // key low sampled in HOLD: armed
        bus.restartKey = 1'b1;
        step();
        check("press2_req", bus.restartRequest, 1);
        bus.restartKey    = 1'b0;
        bus.gameOverEvent = 1'b1;     // sampled while in RESTART
        step();
        bus.gameOverEvent = 1'b0;
        check("restart_ev_busy", bus.busy, 0);
        step();
        check("restart_ev_ignored", bus.busy, 0);
        check("restart_ev_state", bus.dbg_state, 0);
        check("req_count2", req_count, 2);

        // New sequence, then asynchronous reset mid-drop at Y = 8.
        bus.gameOverEvent = 1'b1;
        step();
        bus.gameOverEvent = 1'b0;
        check("restart_new_busy", bus.busy, 1);
        exp_q.push_back({1'b1, 11'd4});
        frame_tick();
        sb_check("drop_r");
        exp_q.push_back({1'b1, 11'd8});
        frame_tick();
        sb_check("drop_r");
        #2;
        resetN = 1'b0;
        #1;
        check("arst_y",    bus.overlayTopLeftY, 0);
        check("arst_vis",  bus.overlayVisible, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_req",  bus.restartRequest, 0);
        step();
        resetN = 1'b1;
        step();
        check("arst_req_count", req_count, 2);

        // Timeout behaviour in HOLD with no key press.
        run_to_hold(1'b0, 1'b0);
        base = req_count;
`ifdef GAMEOVER_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            frame_tick();
            idle_gap();
        end
        check("to_early_req", req_count, base);
        check("to_early_state", bus.dbg_state, 3);
        frame_tick();
        check("to_req", bus.restartRequest, 1);
        step();
        check("to_busy", bus.busy, 0);
        check("to_req_count", req_count, base + 1);
`else
        for (int i = 0; i < 1000; i++) begin
            frame_tick();
            if ($urandom_range(0, 1) == 1) step();
        end
        check("no_to_req_count", req_count, base);
        check("no_to_state", bus.dbg_state, 3);
        check("no_to_busy", bus.busy, 1);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
